// File: rtl/bit_position_scanner_pkg.sv
// Shared defaults and state encoding for the bit position scanner.
package bit_scan_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_POS_W = $clog2(DEF_WIDTH);

  typedef logic state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_EMIT = 1'b1;

endpackage : bit_scan_pkg

// File: rtl/bit_position_scanner_if.sv
// Word-in / position-out handshake bundle of the bit position scanner.
interface bit_scan_if #(
  parameter int WIDTH = bit_scan_pkg::DEF_WIDTH,
  parameter int POS_W = bit_scan_pkg::DEF_POS_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic             match_val;
  logic             pos_valid;
  logic             pos_ready;
  logic [POS_W-1:0] position;
  logic             pos_last;
  logic             pos_none;
  logic [POS_W:0]   count;

  // Producer of words and consumer of positions.
  modport master (
    output in_valid, data_in, match_val, pos_ready,
    input  in_ready, pos_valid, position, pos_last, pos_none, count
  );

  // The scanner itself.
  modport slave (
    input  in_valid, data_in, match_val, pos_ready,
    output in_ready, pos_valid, position, pos_last, pos_none, count
  );

endinterface : bit_scan_if

// File: rtl/bit_position_scanner_lsb_priority_enc.sv
// Lowest-set-bit priority encoder: index of the lowest 1, plus zero and
// single-bit flags. Index reads 0 when the mask is empty.
module lsb_priority_enc #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_mask,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_zero,
  output logic             o_single
);

  logic [WIDTH-1:0] w_low_clr;

  assign w_low_clr = i_mask & (i_mask - WIDTH'(1));
  assign o_zero    = (i_mask == '0);
  assign o_single  = !o_zero && (w_low_clr == '0);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      o_idx = i_mask[i] ? IDX_W'(i) : o_idx;
    end
  end

endmodule : lsb_priority_enc

// File: rtl/bit_position_scanner.sv
// Bit position scanner: captures a word, then emits the positions of the
// bits matching match_val in ascending order, one per handshake.
module bit_position_scanner
  import bit_scan_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int POS_W = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst,
  bit_scan_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mask;
  logic [POS_W:0]   r_count;

  logic [WIDTH-1:0] w_new_mask;
  logic [POS_W:0]   w_popcnt;
  logic [POS_W-1:0] w_enc_idx;
  logic             w_enc_zero;
  logic             w_enc_single;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_xfer;
  logic             w_pos_valid;
  logic [POS_W-1:0] w_position;
  logic             w_pos_last;
  logic             w_pos_none;

  lsb_priority_enc #(
    .WIDTH (WIDTH),
    .IDX_W (POS_W)
  ) u_enc (
    .i_mask   (r_mask),
    .o_idx    (w_enc_idx),
    .o_zero   (w_enc_zero),
    .o_single (w_enc_single)
  );

  assign w_new_mask = bus.match_val ? bus.data_in : ~bus.data_in;
  assign w_in_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_xfer     = w_pos_valid && bus.pos_ready;

  // Count matches in the word being captured.
  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_popcnt = w_popcnt + (POS_W + 1)'(w_new_mask[i]);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: leave EMIT only once the last beat has been taken.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_EMIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (w_xfer && w_pos_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_EMIT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Beat outputs, derived from the remaining mask while emitting.
  always_comb begin
    w_pos_valid = 1'b0;
    w_position  = '0;
    w_pos_last  = 1'b0;
    w_pos_none  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pos_valid = 1'b0;
      end
      ST_EMIT: begin
        w_pos_valid = 1'b1;
        w_position  = w_enc_idx;
        w_pos_last  = w_enc_zero || w_enc_single;
        w_pos_none  = w_enc_zero;
      end
      default: w_pos_valid = 1'b0;
    endcase
  end

  // Remaining-match mask: load on accept, drop the lowest bit per beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= '0;
    end else if (w_accept) begin
      r_mask <= w_new_mask;
    end else if (w_xfer) begin
      r_mask <= r_mask & (r_mask - WIDTH'(1));
    end else begin
      r_mask <= r_mask;
    end
  end

  // Match count of the captured word, held until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= w_popcnt;
    end else begin
      r_count <= r_count;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.pos_valid = w_pos_valid;
  assign bus.position  = w_position;
  assign bus.pos_last  = w_pos_last;
  assign bus.pos_none  = w_pos_none;
  assign bus.count     = r_count;

endmodule : bit_position_scanner
